mac_array_feeder: RTL and testbench

Command-driven sequencer that drives the 2x2 MAC array's control and data inputs. It accepts a command, loads one weight set, clears the accumulators, streams K activations with a programmed routing pattern, waits for the array pipeline to settle, then pulses `done`. It sits between the activation/weight buffers (valid/ready streams) and the MAC array's `valid_ctrl`/`clear`/`valid_weight_in`/`a_in`/`w_*` inputs.

---
 rtl/mac_array_feeder.sv | 205 ++++++++++++++++++++
 tb/tb_mac_array_feeder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_feeder.sv
// mac_array_feeder: command sequencer that loads weights, clears and streams K activations into the 2x2 MAC array.
// Optional STREAM starvation counter is built only when MAC_FEEDER_STALL_CNT_EN is defined.
module mac_array_feeder #(
  parameter int W         = 8,
  parameter int ACC_W     = 16,
  parameter int N_MACS    = 4,
  parameter int K_MAX     = 16,
  parameter int CNT_W     = 5,
  parameter int DRAIN_CYC = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CNT_W-1:0]    cmd_k,
  input  logic [3*N_MACS-1:0] cmd_route,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [4*ACC_W-1:0]  w_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ACC_W-1:0]    a_data,
  output logic [3*N_MACS-1:0] valid_ctrl,
  output logic [N_MACS-1:0]   clear,
  output logic [N_MACS-1:0]   valid_weight_in,
  output logic [ACC_W-1:0]    a_in,
  output logic [ACC_W-1:0]    w_0,
  output logic [ACC_W-1:0]    w_1,
  output logic [ACC_W-1:0]    w_2,
  output logic [ACC_W-1:0]    w_3,
  output logic                busy,
  output logic                done,
  output logic [15:0]         stall_cnt
);

  localparam int DR_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] K_MAX_C    = CNT_W'(K_MAX);
  localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(DRAIN_CYC - 1);

  if (N_MACS != 4) begin : g_bad_n_macs
    $error("mac_array_feeder: N_MACS must be 4");
  end
  if ((2 ** CNT_W) <= K_MAX) begin : g_bad_cnt_w
    $error("mac_array_feeder: CNT_W too narrow for K_MAX");
  end
  if (DRAIN_CYC < 1) begin : g_bad_drain
    $error("mac_array_feeder: DRAIN_CYC must be at least 1");
  end
  if (ACC_W < W) begin : g_bad_acc_w
    $error("mac_array_feeder: ACC_W must not be narrower than W");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [3*N_MACS-1:0]   route_q, route_d;
  logic [CNT_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [CNT_W-1:0]      beat_inc;
  logic [DR_W-1:0]       drain_q, drain_d;
  logic [3*N_MACS-1:0]   vc_q, vc_d;
  logic [N_MACS-1:0]     clear_q, clear_d;
  logic [N_MACS-1:0]     vwi_q, vwi_d;
  logic [ACC_W-1:0]      a_in_q, a_in_d;
  logic [4*ACC_W-1:0]    w_q, w_d;

  assign beat_inc = beat_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and array-side register inputs; pulses default low, data defaults to hold.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    k_d     = k_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    vc_d    = '0;
    clear_d = '0;
    vwi_d   = '0;
    a_in_d  = a_in_q;
    w_d     = w_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          route_d = cmd_route;
          k_d     = (cmd_k > K_MAX_C) ? K_MAX_C : cmd_k;
          beat_d  = '0;
          state_d = (cmd_k == '0) ? S_DONE : S_LOAD_W;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_W: begin
        if (w_valid) begin
          w_d     = w_data;
          clear_d = '1;
          vwi_d   = '1;
          state_d = S_STREAM;
        end else begin
          state_d = S_LOAD_W;
        end
      end
      S_STREAM: begin
        if (a_valid) begin
          a_in_d = a_data;
          vc_d   = route_q;
          beat_d = beat_inc;
          if (beat_inc == k_q) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + {{(DR_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and array-side output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      route_q <= '0;
      k_q     <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      vc_q    <= '0;
      clear_q <= '0;
      vwi_q   <= '0;
      a_in_q  <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      vc_q    <= vc_d;
      clear_q <= clear_d;
      vwi_q   <= vwi_d;
      a_in_q  <= a_in_d;
      w_q     <= w_d;
    end
  end

  assign cmd_ready       = (state_q == S_IDLE);
  assign w_ready         = (state_q == S_LOAD_W);
  assign a_ready         = (state_q == S_STREAM);
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign valid_ctrl      = vc_q;
  assign clear           = clear_q;
  assign valid_weight_in = vwi_q;
  assign a_in            = a_in_q;
  assign w_0             = w_q[ACC_W-1:0];
  assign w_1             = w_q[2*ACC_W-1:ACC_W];
  assign w_2             = w_q[3*ACC_W-1:2*ACC_W];
  assign w_3             = w_q[4*ACC_W-1:3*ACC_W];

`ifdef MAC_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Starvation count: cleared on command accept, saturating on empty STREAM cycles.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && cmd_valid) begin
      stall_d = 16'h0000;
    end else if ((state_q == S_STREAM) && !a_valid && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'h0001;
    end else begin
      stall_d = stall_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mac_array_feeder.sv
// Self-checking bench for mac_array_feeder: per-command timeline model built from the command's
// weight delay and activation valid pattern, compared against the DUT every cycle.
module tb_mac_array_feeder;

  localparam int K_MAX = 16;
  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_k;
  logic [11:0] cmd_route;
  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_data;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] a_data;
  logic [11:0] valid_ctrl;
  logic [3:0]  clear;
  logic [3:0]  valid_weight_in;
  logic [15:0] a_in;
  logic [15:0] w_0, w_1, w_2, w_3;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  mac_array_feeder dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k), .cmd_route(cmd_route),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .valid_ctrl(valid_ctrl), .clear(clear), .valid_weight_in(valid_weight_in), .a_in(a_in),
    .w_0(w_0), .w_1(w_1), .w_2(w_2), .w_3(w_3),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus tables and carried model state
  bit          av[0:127];
  int          av_len;
  logic [15:0] act[0:31];
  logic [15:0] wt[4];
  bit          extra_av;
  logic [63:0] m_w;
  logic [15:0] m_a;
  logic [15:0] m_stall;

  // observations recorded for literal checks
  int          done_t, vc_pulses, clr_t;
  logic [15:0] obs_a[0:255];
  logic [11:0] obs_vc[0:255];
  logic [15:0] stall_obs;

  task automatic chk(input string nm, input int t, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, t, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_cmd_ready"}, 0, cmd_ready, 1);
    chk({nm, "_busy"}, 0, busy, 0);
    chk({nm, "_done"}, 0, done, 0);
    chk({nm, "_w_ready"}, 0, w_ready, 0);
    chk({nm, "_a_ready"}, 0, a_ready, 0);
    chk({nm, "_valid_ctrl"}, 0, valid_ctrl, 0);
    chk({nm, "_clear"}, 0, clear, 0);
    chk({nm, "_vwi"}, 0, valid_weight_in, 0);
    chk({nm, "_a_in"}, 0, a_in, 0);
    chk({nm, "_w"}, 0, {w_3, w_2, w_1, w_0}, 0);
    chk({nm, "_stall"}, 0, stall_cnt, 0);
  endtask

  // Runs one command from an IDLE cycle; expected outputs come from the command's schedule.
  task automatic run_cmd(input int k, input logic [11:0] route, input int d, input bit fixed_pat);
    int kk, lo, s_end, dn, ones, jl, beats;
    bit stream;
    logic [11:0] e_vc;
    logic [15:0] e_a, e_stall;
    logic [63:0] wv, wcur;
    kk = (k > K_MAX) ? K_MAX : k;
    if (!fixed_pat && kk > 0) begin
      ones = 0;
      av_len = 0;
      while (ones < kk) begin
        av[av_len] = (av_len >= 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (av[av_len]) ones++;
        av_len++;
      end
    end
    jl = 0;
    ones = 0;
    for (int j = 0; j < av_len; j++) begin
      if (av[j]) begin
        ones++;
        if (ones == kk) begin
          jl = j;
          break;
        end
      end
    end
    lo = d + 1;
    s_end = lo + jl;
    dn = (kk == 0) ? 0 : s_end + 1 + DRAIN;
    wv = {wt[3], wt[2], wt[1], wt[0]};

    cmd_valid = 1'b1;
    cmd_k = 5'(k);
    cmd_route = route;
    e_vc = '0;
    e_a = m_a;
    e_stall = 16'h0000;
    beats = 0;
    done_t = -1;
    vc_pulses = 0;
    clr_t = -1;
    stall_obs = 16'h0000;
    for (int t = 0; t <= dn + 2; t++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_k = 5'($urandom);
      cmd_route = 12'($urandom);
      if (t < 256) begin
        obs_a[t] = a_in;
        obs_vc[t] = valid_ctrl;
      end
      if (done === 1'b1 && done_t < 0) done_t = t;
      if (clear !== 4'h0 && clr_t < 0) clr_t = t;
      if (valid_ctrl !== 12'h000) vc_pulses++;
      if (t == dn) stall_obs = stall_cnt;

      wcur = (kk > 0 && t >= lo) ? wv : m_w;
      chk("cmd_ready", t, cmd_ready, (t > dn));
      chk("busy", t, busy, (t <= dn));
      chk("done", t, done, (t == dn));
      chk("w_ready", t, w_ready, (kk > 0 && t <= d));
      chk("a_ready", t, a_ready, (kk > 0 && t >= lo && t <= s_end));
      chk("clear", t, clear, (kk > 0 && t == lo) ? 4'hF : 4'h0);
      chk("valid_weight_in", t, valid_weight_in, (kk > 0 && t == lo) ? 4'hF : 4'h0);
      chk("valid_ctrl", t, valid_ctrl, e_vc);
      chk("a_in", t, a_in, e_a);
      chk("w_0", t, w_0, wcur[15:0]);
      chk("w_1", t, w_1, wcur[31:16]);
      chk("w_2", t, w_2, wcur[47:32]);
      chk("w_3", t, w_3, wcur[63:48]);
      chk("stall_cnt", t, stall_cnt, e_stall);

      stream = (kk > 0 && t >= lo && t <= s_end);
      if (stream) begin
        a_valid = av[t-lo];
        a_data = act[beats];
      end else begin
        a_valid = extra_av ? 1'b1 : 1'($urandom_range(0, 1));
        a_data = 16'($urandom);
      end
      if (kk > 0 && t <= d) begin
        w_valid = (t == d);
        w_data = (t == d) ? wv : {$urandom, $urandom};
      end else begin
        w_valid = 1'($urandom_range(0, 1));
        w_data = {$urandom, $urandom};
      end

      if (stream && av[t-lo]) begin
        e_vc = route;
        e_a = act[beats];
        beats++;
      end else begin
        e_vc = '0;
      end
`ifdef MAC_FEEDER_STALL_CNT_EN
      if (stream && !av[t-lo] && e_stall != 16'hFFFF) e_stall = e_stall + 16'h0001;
`endif
    end
    if (kk > 0) m_w = wv;
    m_a = e_a;
    m_stall = e_stall;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_k = '0; cmd_route = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    extra_av = 1'b0;
    m_w = '0; m_a = '0; m_stall = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("post_reset_idle");

    // K=4 basic case
    wt[0] = 16'd1; wt[1] = 16'd2; wt[2] = 16'd3; wt[3] = 16'd4;
    act[0] = 16'd5; act[1] = 16'd6; act[2] = 16'd7; act[3] = 16'd8;
    av_len = 4;
    for (int j = 0; j < 4; j++) av[j] = 1'b1;
    run_cmd(4, 12'h249, 0, 1'b1);
    chk("case1_done_cycle", 0, done_t, 8);
    chk("case1_vc_pulses", 0, vc_pulses, 4);
    chk("case1_clear_cycle", 0, clr_t, 1);
    chk("case1_vc_first", 0, obs_vc[2], 12'h249);
    chk("case1_a_first", 0, obs_a[2], 16'd5);
    chk("case1_a_last", 0, obs_a[5], 16'd8);
    chk("case1_vc_after", 0, obs_vc[6], 12'h000);

    // same command with two bubbles after beat 2
    av_len = 6;
    av[0] = 1'b1; av[1] = 1'b1; av[2] = 1'b0; av[3] = 1'b0; av[4] = 1'b1; av[5] = 1'b1;
    run_cmd(4, 12'h249, 0, 1'b1);
    chk("case2_done_cycle", 0, done_t, 10);
    chk("case2_bubble_vc", 0, obs_vc[4], 12'h000);
    chk("case2_bubble_a_hold", 0, obs_a[5], 16'd6);
`ifdef MAC_FEEDER_STALL_CNT_EN
    chk("case2_stall", 0, stall_obs, 16'd2);
`else
    chk("case2_stall", 0, stall_obs, 16'd0);
`endif

    // zero-length command
    run_cmd(0, 12'hFFF, 0, 1'b0);
    chk("case3_done_cycle", 0, done_t, 0);
    chk("case3_vc_pulses", 0, vc_pulses, 0);

    // clamp of cmd_k=20 to 16 beats with extra activations offered
    for (int j = 0; j < 32; j++) act[j] = 16'($urandom);
    av_len = 16;
    for (int j = 0; j < 16; j++) av[j] = 1'b1;
    extra_av = 1'b1;
    run_cmd(20, 12'h5A5, 0, 1'b1);
    extra_av = 1'b0;
    chk("case4_vc_pulses", 0, vc_pulses, 16);
    chk("case4_done_cycle", 0, done_t, 20);

    // weights arrive 5 cycles after accept
    wt[0] = 16'hA001; wt[1] = 16'hB002; wt[2] = 16'hC003; wt[3] = 16'hD004;
    av_len = 3;
    for (int j = 0; j < 3; j++) av[j] = 1'b1;
    run_cmd(3, 12'h111, 5, 1'b1);
    chk("case6_clear_cycle", 0, clr_t, 6);

    // randomized commands
    for (int n = 0; n < 25; n++) begin
      for (int j = 0; j < 32; j++) act[j] = 16'($urandom);
      for (int j = 0; j < 4; j++) wt[j] = 16'($urandom);
      extra_av = 1'($urandom_range(0, 1));
      run_cmd($urandom_range(0, 20), 12'($urandom), $urandom_range(0, 4), 1'b0);
    end
    extra_av = 1'b0;

    // reset in the middle of a K=8 command, after beat 2
    for (int j = 0; j < 8; j++) act[j] = 16'(j + 100);
    cmd_valid = 1'b1; cmd_k = 5'd8; cmd_route = 12'h0F0;
    w_valid = 1'b1; w_data = 64'h0004_0003_0002_0001;
    a_valid = 1'b1; a_data = act[0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_data = act[1];
    @(posedge clk); #1;
    chk("pre_reset_a_in", 0, a_in, act[1]);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      chk_reset_vals("after_reset");
    end
    m_w = '0; m_a = '0; m_stall = '0;
    act[0] = 16'h1234; act[1] = 16'h5678;
    wt[0] = 16'd9; wt[1] = 16'd10; wt[2] = 16'd11; wt[3] = 16'd12;
    av_len = 2;
    av[0] = 1'b1; av[1] = 1'b1;
    run_cmd(2, 12'h3C3, 0, 1'b1);
    chk("after_reset_done_cycle", 0, done_t, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
